// File: rtl/jux_axi4_wr_slave.sv
// AXI4 write-channel slave: accepts one burst at a time, writes each beat to a
// single-port SRAM and returns the B response.
module jux_axi4_wr_slave #(
  parameter int unsigned DATA_WIDTH     = 2,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 4,
  parameter int unsigned AXLEN_WIDTH    = 8,
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [ID_WIDTH-1:0]           awid,
  input  logic [ADDR_WIDTH-1:0]         awaddr,
  input  logic [AXLEN_WIDTH-1:0]        awlen,
  input  logic [2:0]                    awsize,
  input  logic [1:0]                    awburst,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [(8<<DATA_WIDTH)-1:0]    wdata,
  input  logic [(1<<DATA_WIDTH)-1:0]    wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  output logic [ID_WIDTH-1:0]           bid,
  output logic [1:0]                    bresp,
  output logic                          bvalid,
  input  logic                          bready,
  output logic                          mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]     mem_addr,
  output logic [(8<<DATA_WIDTH)-1:0]    mem_wdata,
  output logic [(1<<DATA_WIDTH)-1:0]    mem_wstrb
);

  localparam int unsigned DATA_W = 8 << DATA_WIDTH;
  localparam int unsigned STRB_W = 1 << DATA_WIDTH;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [AXLEN_WIDTH-1:0]      len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [AXLEN_WIDTH-1:0]      cnt_q, cnt_d;
  logic                        err_q, err_d;
  logic                        nowrite_q, nowrite_d;

  logic                        awready_d, wready_d, bvalid_d, mem_we_d;
  logic [ID_WIDTH-1:0]         bid_d;
  logic [1:0]                  bresp_d;
  logic [MEM_ADDR_WIDTH-1:0]   mem_addr_d;
  logic [DATA_W-1:0]           mem_wdata_d;
  logic [STRB_W-1:0]           mem_wstrb_d;

  logic                        aw_hs, w_hs, last_beat, last_err, aw_bad;
  logic [ADDR_WIDTH-1:0]       beat_bytes, wrap_bytes, wrap_lower, addr_inc, addr_next;

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign last_beat = (cnt_q == len_q);
  // wlast must coincide exactly with the final beat
  assign last_err  = (wlast != last_beat);

  // Burst descriptors that are rejected up front: beats are drained but never written
  assign aw_bad = (awsize > 3'(DATA_WIDTH)) ||
                  (awburst == 2'b11) ||
                  ((awburst == BURST_WRAP) &&
                   !((awlen == AXLEN_WIDTH'(1)) || (awlen == AXLEN_WIDTH'(3)) ||
                     (awlen == AXLEN_WIDTH'(7)) || (awlen == AXLEN_WIDTH'(15))));

  assign beat_bytes = ADDR_WIDTH'(1) << size_q;
  assign wrap_bytes = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
  assign wrap_lower = addr_q & ~(wrap_bytes - ADDR_WIDTH'(1));
  assign addr_inc   = addr_q + beat_bytes;

  // Byte address of the beat following the current one
  always_comb begin
    addr_next = addr_q;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_INCR:  addr_next = (addr_q & ~(beat_bytes - ADDR_WIDTH'(1))) + beat_bytes;
      BURST_WRAP:  addr_next = (addr_inc == (wrap_lower + wrap_bytes)) ? wrap_lower : addr_inc;
      default:     addr_next = addr_q;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    nowrite_d   = nowrite_q;
    bid_d       = bid;
    bresp_d     = bresp;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;

    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          bid_d     = awid;
          addr_d    = awaddr;
          len_d     = awlen;
          size_d    = awsize;
          burst_d   = awburst;
          cnt_d     = '0;
          err_d     = aw_bad;
          nowrite_d = aw_bad;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          mem_we_d    = ~nowrite_q;
          mem_addr_d  = addr_q[MEM_ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          mem_wdata_d = wdata;
          mem_wstrb_d = wstrb;
          addr_d      = addr_next;
          cnt_d       = cnt_q + AXLEN_WIDTH'(1);
          err_d       = err_q | last_err;
          if (last_beat) begin
            bresp_d = (err_q | last_err) ? RESP_SLVERR : RESP_OKAY;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bvalid && bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Registered outputs and burst context
  always_ff @(posedge aclk) begin
    if (areset) begin
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= RESP_OKAY;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      nowrite_q <= 1'b0;
    end else begin
      awready   <= awready_d;
      wready    <= wready_d;
      bvalid    <= bvalid_d;
      bid       <= bid_d;
      bresp     <= bresp_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      nowrite_q <= nowrite_d;
    end
  end

endmodule

// File: tb/tb_jux_axi4_wr_slave.sv
// Scoreboard bench for jux_axi4_wr_slave: stimulus pushes expected SRAM writes
// and B responses, a negedge monitor pops and compares them.
module tb_jux_axi4_wr_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  jux_axi4_wr_slave dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [9:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_t;

  wr_t exp_wr[$];
  b_t  exp_b[$];
  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting, expected handshake (t=%0t)", name, $time);
  endtask

  // Monitor: compare every SRAM write and B handshake against the scoreboard
  always @(negedge aclk) begin
    if (mon_en) begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_write_unexpected: got addr=%0h data=%0h strb=%0h expected no write",
                   mem_addr, mem_wdata, mem_wstrb);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("mem_addr", 64'(mem_addr), 64'(e.a));
          chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
          chk("mem_wstrb", 64'(mem_wstrb), 64'(e.s));
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected: got bid=%0h bresp=%0h expected no response", bid, bresp);
        end else begin
          b_t e;
          e = exp_b.pop_front();
          chk("bid", 64'(bid), 64'(e.id));
          chk("bresp", 64'(bresp), 64'(e.resp));
        end
      end
    end
  end

  task automatic push_wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t e;
    e.a = a; e.d = d; e.s = s;
    exp_wr.push_back(e);
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    b_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (awready) break;
      n++;
      if (n > 50) begin timeout("aw_accept"); break; end
    end
    @(posedge aclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input logic last);
    int n = 0;
    wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (wready) break;
      n++;
      if (n > 50) begin timeout("w_accept"); break; end
    end
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    forever begin
      @(negedge aclk);
      if (bvalid && bready) break;
      n++;
      if (n > 50) begin timeout("b_handshake"); break; end
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    logic [3:0] strbs [3];
    int n;
    strbs[0] = 4'b0001; strbs[1] = 4'b0010; strbs[2] = 4'b1100;
    areset = 1'b1; bready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    areset = 1'b0;
    mon_en = 1'b1;
    @(posedge aclk); #1;
    chk("awready_after_reset", 64'(awready), 64'd1);

    // INCR 0x10, 4 beats of 4 bytes -> words 4..7
    push_b(4'h5, 2'b00);
    do_aw(4'h5, 32'h10, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      push_wr(10'(4 + i), 32'hA000_0000 + 32'(i), 4'hF);
      do_w(32'hA000_0000 + 32'(i), 4'hF, i == 3);
    end
    wait_b();
    chk("awready_after_b_incr", 64'(awready), 64'd1);

    // WRAP 0x38, 4 beats -> words E,F,C,D
    push_b(4'h2, 2'b00);
    do_aw(4'h2, 32'h38, 8'd3, 3'd2, 2'b10);
    push_wr(10'hE, 32'hB000_0000, 4'hF);
    push_wr(10'hF, 32'hB000_0001, 4'hF);
    push_wr(10'hC, 32'hB000_0002, 4'hF);
    push_wr(10'hD, 32'hB000_0003, 4'hF);
    for (int i = 0; i < 4; i++) do_w(32'hB000_0000 + 32'(i), 4'hF, i == 3);
    wait_b();

    // FIXED 0x20, 3 beats at word 8 with differing strobes
    push_b(4'h3, 2'b00);
    do_aw(4'h3, 32'h20, 8'd2, 3'd2, 2'b00);
    for (int i = 0; i < 3; i++) begin
      push_wr(10'h8, 32'hC000_0000 + 32'(i), strbs[i]);
      do_w(32'hC000_0000 + 32'(i), strbs[i], i == 2);
    end
    wait_b();

    // Oversized beat: drained, no writes, SLVERR
    push_b(4'h6, 2'b10);
    do_aw(4'h6, 32'h0, 8'd1, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) do_w(32'hD000_0000 + 32'(i), 4'hF, i == 1);
    wait_b();

    // Early wlast on beat 1 of 4: all four written, SLVERR
    push_b(4'h7, 2'b10);
    do_aw(4'h7, 32'h40, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) begin
      push_wr(10'(16 + i), 32'hE000_0000 + 32'(i), 4'hF);
      do_w(32'hE000_0000 + 32'(i), 4'hF, i == 1);
    end
    wait_b();

    // WRAP with illegal length 3 beats: drained, no writes, SLVERR
    push_b(4'h8, 2'b10);
    do_aw(4'h8, 32'h0, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) do_w(32'hF000_0000 + 32'(i), 4'hF, i == 2);
    wait_b();

    // B backpressure: response held stable while bready is low
    bready = 1'b0;
    push_b(4'h9, 2'b00);
    do_aw(4'h9, 32'h80, 8'd0, 3'd2, 2'b01);
    push_wr(10'h20, 32'h1234_5678, 4'hF);
    do_w(32'h1234_5678, 4'hF, 1'b1);
    n = 0;
    forever begin
      @(negedge aclk);
      if (bvalid) break;
      n++;
      if (n > 50) begin timeout("bvalid_rise"); break; end
    end
    for (int k = 0; k < 5; k++) begin
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bid", 64'(bid), 64'h9);
      chk("hold_bresp", 64'(bresp), 64'd0);
      chk("hold_awready", 64'(awready), 64'd0);
      @(negedge aclk);
    end
    @(posedge aclk); #1;
    bready = 1'b1;
    wait_b();
    chk("awready_after_held_b", 64'(awready), 64'd1);
    chk("bvalid_after_held_b", 64'(bvalid), 64'd0);

    // Reset during beat 2 of an 8-beat burst
    do_aw(4'hA, 32'h100, 8'd7, 3'd2, 2'b01);
    push_wr(10'h40, 32'h5500_0000, 4'hF);
    do_w(32'h5500_0000, 4'hF, 1'b0);
    push_wr(10'h41, 32'h5500_0001, 4'hF);
    do_w(32'h5500_0001, 4'hF, 1'b0);
    wdata = 32'h5500_0002; wstrb = 4'hF; wvalid = 1'b1; areset = 1'b1;
    @(posedge aclk); #1;
    chk("mid_rst_awready", 64'(awready), 64'd0);
    chk("mid_rst_wready", 64'(wready), 64'd0);
    chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
    chk("mid_rst_bid", 64'(bid), 64'd0);
    chk("mid_rst_bresp", 64'(bresp), 64'd0);
    chk("mid_rst_mem_we", 64'(mem_we), 64'd0);
    chk("mid_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    wvalid = 1'b0; areset = 1'b0;
    @(posedge aclk); #1;
    chk("awready_after_mid_rst", 64'(awready), 64'd1);

    // Fresh burst after the aborted one
    push_b(4'hB, 2'b00);
    do_aw(4'hB, 32'h200, 8'd1, 3'd2, 2'b01);
    for (int i = 0; i < 2; i++) begin
      push_wr(10'(128 + i), 32'h6600_0000 + 32'(i), 4'hF);
      do_w(32'h6600_0000 + 32'(i), 4'hF, i == 1);
    end
    wait_b();

    repeat (5) @(negedge aclk);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    chk("b_queue_drained", 64'(exp_b.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
